// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-side defaults and instruction-bus bundle types.
// Used by rv_fetch_req and its neighbours on the instruction bus.
package rv_fetch_pkg;

  localparam int unsigned RV_FETCH_RESET_ADDR = 0;
  localparam int unsigned RV_FETCH_ABITS      = 16;
  localparam int unsigned RV_FETCH_DBITS      = 32;

  typedef struct packed {
    logic                      req;
    logic [RV_FETCH_ABITS-3:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic                      ack;
    logic                      rvalid;
    logic [RV_FETCH_DBITS-1:0] rdata;
  } ibus_rsp_t;

endpackage

// File: rtl/rv_fetch_req_add.sv
// rv_fetch_req_add: plain wrap-around adder.
// Ports: i_op1, i_op2 operands; o_sum = i_op1 + i_op2 (mod 2**WIDTH).
module rv_fetch_req_add #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_op1 + i_op2;

endmodule

// File: rtl/rv_fetch_req.sv
// rv_fetch_req: issues word reads, tracks in-flight responses, pushes into
// the fetch buffer only with guaranteed space; flushes/retargets on redirect.
// Ports: i_redirect/i_redirect_pc (half units), i_buf_free, bus o_req/o_addr/
// i_ack/i_rvalid/i_rdata, buffer o_push/o_data/o_flush/o_pc.
module rv_fetch_req
  import rv_fetch_pkg::*;
#(
  parameter int          IADDR_SPACE_BITS = 16,
  parameter int          WIDTH            = 32,
  parameter int          DEPTH_BITS       = 2,
  parameter int          PEND_BITS        = 2,
  parameter int unsigned RESET_ADDR       = RV_FETCH_RESET_ADDR
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_redirect,
  input  logic [IADDR_SPACE_BITS-2:0] i_redirect_pc,
  input  logic [DEPTH_BITS:0]         i_buf_free,
  output logic                        o_req,
  output logic [IADDR_SPACE_BITS-3:0] o_addr,
  input  logic                        i_ack,
  input  logic                        i_rvalid,
  input  logic [WIDTH-1:0]            i_rdata,
  output logic                        o_push,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_flush,
  output logic [IADDR_SPACE_BITS-2:0] o_pc
);

  localparam int AW = IADDR_SPACE_BITS - 2;
  localparam int PW = IADDR_SPACE_BITS - 1;
  localparam int CW =
    ((PEND_BITS > DEPTH_BITS + 1) ? PEND_BITS : DEPTH_BITS + 1) + 1;
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
  localparam logic [PW-1:0]        RST_PC   = PW'(RESET_ADDR);
  localparam logic [AW-1:0]        RST_WORD = RST_PC[PW-1:1];

  logic [AW-1:0]        fa;
  logic [AW-1:0]        req_addr;
  logic [AW-1:0]        inc;
  logic [AW-1:0]        tgt;
  logic [PEND_BITS-1:0] pend;
  logic [PEND_BITS-1:0] discard;
  logic [PEND_BITS-1:0] pend_next;
  logic [PEND_BITS-1:0] live_cnt;
  logic                 stale_hold;
  logic                 flush_r;
  logic [PW-1:0]        pc_r;
  logic                 fire;
  logic                 drop;

  rv_fetch_req_add #(
    .WIDTH (AW)
  ) u_inc (
    .i_op1 (req_addr),
    .i_op2 (AW'(1)),
    .o_sum (inc)
  );

  assign tgt       = i_redirect_pc[PW-1:1];
  assign live_cnt  = pend - discard;
  // A held (now stale) request must stay on the bus until accepted,
  // even through the flush cycle.
  assign o_req     = stale_hold |
                     (~flush_r &
                      (CW'(live_cnt) < CW'(i_buf_free)) &
                      (pend != PEND_MAX));
  assign fire      = o_req & i_ack;
  assign pend_next = pend + PEND_BITS'(fire) - PEND_BITS'(i_rvalid);
  assign drop      = i_rvalid & (discard != '0);

  assign o_addr  = req_addr;
  assign o_push  = i_rvalid & ~drop & ~i_redirect;
  assign o_data  = i_rdata;
  assign o_flush = flush_r;
  assign o_pc    = pc_r;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fa         <= RST_WORD;
      req_addr   <= RST_WORD;
      pend       <= '0;
      discard    <= '0;
      stale_hold <= 1'b0;
      flush_r    <= 1'b1;
      pc_r       <= RST_PC;
    end else begin
      pend    <= pend_next;
      flush_r <= i_redirect;
      if (i_redirect) begin
        pc_r    <= i_redirect_pc;
        fa      <= tgt;
        discard <= pend_next;
        if (o_req & ~i_ack) begin
          stale_hold <= 1'b1;
        end else begin
          stale_hold <= 1'b0;
          req_addr   <= tgt;
        end
      end else begin
        discard <= discard - PEND_BITS'(drop)
                 + PEND_BITS'(stale_hold & fire);
        if (fire) begin
          stale_hold <= 1'b0;
          req_addr   <= stale_hold ? fa : inc;
          if (!stale_hold) fa <= inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_fetch_req.sv
// tb_rv_fetch_req: randomized bus/buffer stimulus against a transaction-level
// model; expected pushes go through a scoreboard queue checked by a monitor.
module tb_rv_fetch_req;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        red;
  logic [14:0] red_pc;
  logic [2:0]  buf_free;
  logic        req;
  logic [13:0] addr;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  logic        push;
  logic [31:0] data;
  logic        flush;
  logic [14:0] pc;

  rv_fetch_req #(
    .IADDR_SPACE_BITS (16),
    .WIDTH            (32),
    .DEPTH_BITS       (2),
    .PEND_BITS        (2),
    .RESET_ADDR       (0)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_redirect    (red),
    .i_redirect_pc (red_pc),
    .i_buf_free    (buf_free),
    .o_req         (req),
    .o_addr        (addr),
    .i_ack         (ack),
    .i_rvalid      (rvalid),
    .i_rdata       (rdata),
    .o_push        (push),
    .o_data        (data),
    .o_flush       (flush),
    .o_pc          (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        inflight[$];
  logic [31:0] sb[$];
  int          vec = 0;
  int          bad = 0;
  logic [13:0] exp_addr;
  logic [13:0] held_addr;
  logic [14:0] exp_pc;
  bit          held;
  bit          exp_flush;
  bit          force46 = 0;
  int          occ;

  function automatic logic [31:0] mem(logic [13:0] a);
    return {2'b10, a, ~a} ^ 32'h5A3C_0000;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] ex);
    vec++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, ex, $time);
    end
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && push) begin
        if (sb.size() == 0) begin
          chk("spurious_push", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("push_data", data, e);
        end
      end
    end
  end

  task automatic cyc(int pa, int pv, int pd, int pc_pct);
    ent_t e;
    bit   r;
    bit   a;
    bit   v;
    bit   cons;
    @(posedge clk);
    #1;
    buf_free = 3'(4 - occ);
    r = force46 || ($urandom_range(99) < pd);
    red = r;
    red_pc = force46 ? 15'h0046 : 15'($urandom);
    force46 = 0;
    v = (inflight.size() > 0) && ($urandom_range(99) < pv);
    rvalid = v;
    rdata = 32'h0;
    if (v) begin
      e = inflight.pop_front();
      rdata = e.d;
      if (e.live && !r) sb.push_back(e.d);
    end
    #1;
    a = req && ($urandom_range(99) < pa);
    ack = a;
    @(negedge clk);
    chk("flush", flush, exp_flush);
    if (exp_flush) chk("flush_pc", pc, exp_pc);
    if (held) chk("held_req", req, 1);
    else if (exp_flush) chk("flush_quiet", req, 0);
    if (req) chk("addr", addr, held ? held_addr : exp_addr);
    if (push) chk("overflow", occ < 4, 1);
    if (req && a) begin
      if (held) begin
        inflight.push_back('{mem(held_addr), 1'b0});
        held = 0;
      end else begin
        inflight.push_back('{mem(exp_addr), 1'b1});
        exp_addr = exp_addr + 14'd1;
      end
      chk("pend_cap", inflight.size() <= 3, 1);
    end
    if (r) begin
      foreach (inflight[i]) inflight[i].live = 0;
      if (req && !a && !held) begin
        held = 1;
        held_addr = exp_addr;
      end
      exp_addr = red_pc[14:1];
      exp_pc = red_pc;
    end
    cons = (occ > 0) && ($urandom_range(99) < pc_pct);
    occ = flush ? 0 : occ + int'(push) - int'(cons);
    exp_flush = r;
  endtask

  task automatic do_reset();
    red = 0;
    ack = 0;
    rvalid = 0;
    rdata = 0;
    red_pc = 0;
    buf_free = 3'd4;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_push", push, 0);
    chk("rst_flush", flush, 1);
    chk("rst_pc", pc, 0);
    chk("rst_addr", addr, 0);
    inflight.delete();
    sb.delete();
    held = 0;
    occ = 0;
    exp_addr = 0;
    exp_pc = 0;
    exp_flush = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_flush", flush, 1);
    chk("rel_req", req, 0);
    @(posedge clk);
    #1;
    buf_free = 3'd4;
    #1;
    chk("first_req", req, 1);
    chk("first_addr", addr, 0);
    chk("first_flush", flush, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && held; i++) cyc(100, 100, 0, 50);
    for (int i = 0; i < 40 && inflight.size() > 0; i++) cyc(0, 100, 0, 50);
    cyc(0, 100, 0, 50);
    chk("drain_held", held, 0);
    chk("drain_inflight", inflight.size(), 0);
    chk("drain_sb", sb.size(), 0);
  endtask

  initial begin
    do_reset();
    repeat (30) cyc(100, 100, 0, 100);
    repeat (30) cyc(100, 50, 0, 0);
    repeat (20) cyc(100, 100, 0, 100);
    repeat (5) cyc(100, 0, 0, 100);
    force46 = 1;
    cyc(100, 0, 0, 100);
    repeat (20) cyc(100, 100, 0, 100);
    repeat (400) cyc(60, 50, 8, 50);
    repeat (300) cyc(30, 70, 15, 30);
    drain();
    repeat (50) cyc(70, 50, 5, 60);
    do_reset();
    repeat (300) cyc(60, 50, 8, 50);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
